// File: rtl/pi_digit_reader_pkg.sv
// Shared definitions for the pi digit ROM reader: digit packing, default ROM latency,
// controller state encoding and the bad-word test applied to every loaded word.
package pi_defs;
    localparam int DIGITS_PER_WORD = 4;
    localparam int DIGIT_W         = 4;
    localparam int READ_LAT_DEF    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reserved bits must be zero and every nibble must be a decimal digit.
    function automatic logic word_bad(input logic [17:0] w);
        logic bad;
        bad = (w[17:16] != 2'b00);
        for (int i = 0; i < DIGITS_PER_WORD; i++) begin
            if (w[i*DIGIT_W +: DIGIT_W] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
endpackage

// File: rtl/pi_word_fifo.sv
// Synchronous show-ahead word FIFO: head is valid whenever empty is low, zero read latency.
// Push and pop may coincide; a push while full is dropped unless a pop frees the slot.
module pi_word_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/pi_digit_reader.sv
// Walks the pi ROM, re-times its fixed read latency into a word FIFO and streams BCD digits MSD first.
// First digit 6 cycles after start; issue is credit-limited so backpressure never drops a word.
module pi_digit_reader
    import pi_defs::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 18,
    parameter int N_WORDS    = 24 * 512,
    parameter int READ_LAT   = READ_LAT_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_data,
    output logic               dig_valid,
    input  logic               dig_ready,
    output logic [DIGIT_W-1:0] dig_data,
    output logic               dig_last
);
    localparam int IW  = $clog2(READ_LAT + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int LW  = $clog2(N_WORDS + 1);
    localparam int XW  = $clog2(DIGITS_PER_WORD);
    localparam logic [XW-1:0] LAST_IDX = XW'(DIGITS_PER_WORD - 1);

    state_t            state;
    logic [READ_LAT-1:0] vld_sr;
    logic [IW-1:0]     inflight;
    logic [FCW-1:0]    fifo_count;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              start_acc;
    logic              issue;
    logic              hs;
    logic              load;
    logic [DATA_W-1:0] word_q;
    logic [XW-1:0]     idx;
    logic              cur_last;
    logic [LW-1:0]     load_cnt;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) inflight = inflight + IW'(vld_sr[i]);
    end

    // Words in flight plus words buffered may never exceed the FIFO, so capture can't overflow.
    assign issue     = (state == RUN) && ((int'(inflight) + int'(fifo_count)) < FIFO_DEPTH);
    assign start_acc = (state == IDLE) && start && !busy;
    assign hs        = dig_valid && dig_ready;
    assign load      = (!dig_valid || (hs && idx == LAST_IDX)) && !fifo_empty;
    assign dig_data  = word_q[DIGIT_W*(DIGITS_PER_WORD-1-int'(idx)) +: DIGIT_W];
    assign dig_last  = dig_valid && cur_last && (idx == LAST_IDX);

    pi_word_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_sr[READ_LAT-1]),
        .push_data (mem_data),
        .pop       (load),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
            vld_sr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_sr <= (vld_sr << 1) | READ_LAT'(issue);
            if (done) busy <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        mem_addr <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (mem_addr == ADDR_W'(N_WORDS - 1)) state <= DRAIN;
                        else mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (hs && dig_last && inflight == '0 && fifo_empty) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q    <= '0;
            idx       <= '0;
            dig_valid <= 1'b0;
            cur_last  <= 1'b0;
            load_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            if (start_acc) begin
                load_cnt <= '0;
                err      <= 1'b0;
            end else if (load) begin
                load_cnt <= load_cnt + LW'(1);
                err      <= err | word_bad(fifo_head);
            end
            if (load) begin
                word_q    <= fifo_head;
                idx       <= '0;
                dig_valid <= 1'b1;
                cur_last  <= (load_cnt == LW'(N_WORDS - 1));
            end else if (hs) begin
                if (idx == LAST_IDX) dig_valid <= 1'b0;
                else idx <= idx + XW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pi_digit_reader.sv
// Bench for pi_digit_reader: ROM modelled as a 3-stage address pipeline, digits checked
// against a sequence derived arithmetically from the ROM contents.
module tb_pi_digit_reader;
    localparam int NW = 8;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [23:0] mem_addr;
    logic [17:0] mem_data;
    logic        dig_valid;
    logic        dig_ready;
    logic [3:0]  dig_data;
    logic        dig_last;

    logic [17:0] rom [NW];
    logic [23:0] p1 = '0, p2 = '0, p3 = '0;

    int errors = 0;
    int checks = 0;
    int got_dig[$];
    int got_last[$];
    int exp_dig[$];
    int first_cyc, last_cyc, done_cyc, done_count, busy_gap, busy_after, max_addr, err_rise, last_count;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1 <= mem_addr;
        p2 <= p1;
        p3 <= p2;
    end
    assign mem_data = rom[p3[2:0]];

    pi_digit_reader #(
        .ADDR_W(24), .DATA_W(18), .N_WORDS(NW), .READ_LAT(3), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_data(mem_data), .dig_valid(dig_valid),
        .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last)
    );

    function automatic logic [17:0] good_word();
        return 18'($urandom_range(0, 9) * 4096 + $urandom_range(0, 9) * 256 +
                   $urandom_range(0, 9) * 16 + $urandom_range(0, 9));
    endfunction

    task automatic fill_good();
        for (int w = 0; w < NW; w++) rom[w] = good_word();
    endtask

    task automatic build_exp();
        exp_dig.delete();
        for (int w = 0; w < NW; w++)
            for (int j = 0; j < 4; j++)
                exp_dig.push_back((int'(rom[w]) % 65536) / (16 ** (3 - j)) % 16);
    endtask

    function automatic int seq_errs();
        int n = 0;
        if (got_dig.size() != exp_dig.size()) return 1000 + got_dig.size();
        for (int i = 0; i < exp_dig.size(); i++) begin
            if (got_dig[i] != exp_dig[i]) n++;
            if (got_last[i] != int'(i == exp_dig.size() - 1)) n++;
        end
        return n;
    endfunction

    // mode: 0 full ready, 1 toggling, 2 random, 3 50-cycle stall after first digit
    task automatic run_read(input int mode, input bit spam);
        bit r;
        bit stalling;
        got_dig.delete(); got_last.delete();
        first_cyc = -1; last_cyc = -1; done_cyc = -1; done_count = 0;
        busy_gap = 0; busy_after = 0; max_addr = 0; err_rise = -1; last_count = 0;
        @(posedge clk); #1;
        start = 1'b1; dig_ready = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            @(posedge clk); #1;
            start = spam && (c == 9 || c == 21 || c == 6 + 4 * NW);
            stalling = (first_cyc >= 0) && (c > first_cyc) && (c <= first_cyc + 50);
            case (mode)
                0:       r = 1'b1;
                1:       r = c[0];
                2:       r = 1'($urandom % 2);
                default: r = !stalling;
            endcase
            dig_ready = r;
            if (err && err_rise < 0) err_rise = c;
            if (stalling && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (done_cyc < 0 && !busy) busy_gap++;
            if (done_cyc >= 0 && busy) busy_after++;
            if (dig_valid) begin
                if (first_cyc < 0) first_cyc = c;
                if (r) begin
                    got_dig.push_back(int'(dig_data));
                    got_last.push_back(int'(dig_last));
                    if (dig_last) begin last_count++; last_cyc = c; end
                end
            end
            if (done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0;
        dig_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dig_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, dig_valid, dig_last} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, dig_valid, dig_last});
        end
        checks++;
        if ({mem_addr, dig_data} !== 28'h0) begin
            errors++; $display("FAIL reset_data: addr=%0h data=%0h expected 0", mem_addr, dig_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_rate();
        int e;
        fill_good();
        rom[0] = 18'h01415; rom[1] = 18'h09265; rom[2] = 18'h03589;
        build_exp();
        run_read(0, 1'b0);
        e = seq_errs();
        checks++;
        if (e !== 0) begin errors++; $display("FAIL full_seq: %0d digit/last errors, expected 0", e); end
        checks++;
        if (first_cyc !== 6) begin errors++; $display("FAIL full_first: cycle %0d expected 6", first_cyc); end
        checks++;
        if (last_cyc !== 6 + 4 * NW - 1) begin errors++; $display("FAIL full_last: cycle %0d expected %0d", last_cyc, 6 + 4 * NW - 1); end
        checks++;
        if (done_cyc !== 6 + 4 * NW) begin errors++; $display("FAIL full_done: cycle %0d expected %0d", done_cyc, 6 + 4 * NW); end
        checks++;
        if (busy_gap !== 0 || busy_after !== 0) begin
            errors++; $display("FAIL full_busy: gap=%0d after=%0d expected 0/0", busy_gap, busy_after);
        end
        checks++;
        if (err_rise !== -1) begin errors++; $display("FAIL full_err: rose at %0d expected never", err_rise); end
    endtask

    task automatic test_backpressure();
        int e;
        fill_good(); build_exp();
        run_read(1, 1'b0);
        e = seq_errs();
        checks++;
        if (e !== 0) begin errors++; $display("FAIL toggle_seq: %0d errors expected 0", e); end
        checks++;
        if (done_count !== 1 || last_count !== 1) begin
            errors++; $display("FAIL toggle_done: done=%0d last=%0d expected 1/1", done_count, last_count);
        end
        fill_good(); build_exp();
        run_read(2, 1'b0);
        e = seq_errs();
        checks++;
        if (e !== 0 || done_count !== 1) begin
            errors++; $display("FAIL random_ready: seq_errs=%0d done=%0d expected 0/1", e, done_count);
        end
    endtask

    task automatic test_long_stall();
        int e;
        fill_good(); build_exp();
        run_read(3, 1'b0);
        // One word sits in the unpacker, FD more may be buffered or in flight; next address waits.
        checks++;
        if (max_addr !== FD + 1) begin errors++; $display("FAIL stall_outstanding: max addr %0d expected %0d", max_addr, FD + 1); end
        e = seq_errs();
        checks++;
        if (e !== 0 || done_count !== 1) begin
            errors++; $display("FAIL stall_seq: seq_errs=%0d done=%0d expected 0/1", e, done_count);
        end
    endtask

    task automatic test_bad_word();
        int e;
        fill_good();
        rom[2] = 18'h20000 | (good_word() & 18'h0FFFF);
        build_exp();
        run_read(0, 1'b0);
        checks++;
        if (err_rise !== 6 + 4 * 2) begin errors++; $display("FAIL err_reserved: rose %0d expected %0d", err_rise, 14); end
        e = seq_errs();
        checks++;
        if (e !== 0) begin errors++; $display("FAIL err_reserved_seq: %0d errors expected 0", e); end
        fill_good();
        rom[5][7:4] = 4'hA;
        build_exp();
        run_read(0, 1'b0);
        checks++;
        if (err_rise !== 6 + 4 * 5) begin errors++; $display("FAIL err_nibble: rose %0d expected %0d", err_rise, 26); end
        e = seq_errs();
        checks++;
        if (e !== 0) begin errors++; $display("FAIL err_nibble_seq: %0d errors expected 0", e); end
        fill_good(); build_exp();
        run_read(0, 1'b0);
        checks++;
        if (err_rise !== -1) begin errors++; $display("FAIL err_clear: rose %0d expected never", err_rise); end
    endtask

    task automatic test_reset_mid_drain();
        int hit = -1;
        int e;
        fill_good();
        rom[0] = 18'h0A000;
        @(posedge clk); #1;
        start = 1'b1; dig_ready = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (hit >= 0) begin rst_n = 1'b0; break; end
            if (mem_addr == 24'(NW - 1)) hit = c;
        end
        checks++;
        if (hit < 0) begin errors++; $display("FAIL drain_reach: last address never seen, expected within 200 cycles"); end
        @(posedge clk); #1;
        checks++;
        if ({busy, done, err, dig_valid, dig_last, mem_addr, dig_data} !== 33'h0) begin
            errors++; $display("FAIL drain_reset: busy=%b done=%b err=%b vld=%b last=%b addr=%0h data=%0h expected all 0",
                               busy, done, err, dig_valid, dig_last, mem_addr, dig_data);
        end
        rst_n = 1'b1;
        fill_good(); build_exp();
        run_read(0, 1'b0);
        e = seq_errs();
        checks++;
        if (e !== 0 || first_cyc !== 6 || done_count !== 1) begin
            errors++; $display("FAIL drain_restart: seq_errs=%0d first=%0d done=%0d expected 0/6/1", e, first_cyc, done_count);
        end
    endtask

    task automatic test_start_spam();
        int e;
        fill_good(); build_exp();
        run_read(0, 1'b1);
        checks++;
        if (done_count !== 1 || busy_after !== 0) begin
            errors++; $display("FAIL spam_done: done=%0d busy_after=%0d expected 1/0", done_count, busy_after);
        end
        e = seq_errs();
        checks++;
        if (e !== 0 || done_cyc !== 6 + 4 * NW) begin
            errors++; $display("FAIL spam_seq: seq_errs=%0d done_cyc=%0d expected 0/%0d", e, done_cyc, 6 + 4 * NW);
        end
    endtask

    initial begin
        for (int w = 0; w < NW; w++) rom[w] = '0;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_long_stall();
        test_bad_word();
        test_reset_mid_drain();
        test_start_spam();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pi_digit_reader.md
# pi_digit_reader

Read-side master for the pi digit ROM. On a start pulse it walks the ROM address space, compensates for the ROM's fixed 3-cycle read latency, and unpacks each 18-bit word into four BCD digits. Digits leave on a valid/ready stream toward the screen renderer. Flow control is credit-based, so backpressure never drops or reorders a word.

## Interface
Parameters:
- ADDR_W, 24, ROM address width
- DATA_W, 18, ROM word width; fixed at 18 by the packing format
- N_WORDS, 24*512, words per full read; total digits = 4*N_WORDS
- READ_LAT, 3, ROM cycles from address to data
- FIFO_DEPTH, 4, word buffer entries; must be >= 2

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a full read; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last digit is accepted
- err  out  1  sticky bad-word flag; cleared by an accepted start
- mem_addr  out  ADDR_W  registered ROM address
- mem_data  in  DATA_W  ROM read data
- dig_valid  out  1  digit available
- dig_ready  in  1  sink accepts the digit when valid and ready are both high
- dig_data  out  4  BCD digit
- dig_last  out  1  high with the final digit of the read

## Operation
- Word format: [15:12] is the first digit, [11:8] second, [7:4] third, [3:0] fourth; [17:16] are reserved zero.
- States:
  - IDLE: accepted start clears the address counter and err, then goes to RUN.
  - RUN: issues one address per cycle while credit allows; after address N_WORDS-1 is issued, goes to DRAIN.
  - DRAIN: waits until in-flight reads = 0, FIFO empty and the last digit is accepted; then pulses done and goes to IDLE.
- Issue:
  - An address is issued in a cycle where mem_addr holds a new value and the issue bit is pushed into a READ_LAT-deep valid shift register.
  - Credit rule: issue only when inflight + fifo_count < FIFO_DEPTH. This guarantees no FIFO overflow.
- Capture: when the valid shift register output is 1, mem_data is written into the FIFO that same cycle.
- Unpacker:
  - Holds one word plus a digit index 0..3 and emits the digits MSD first.
  - On the cycle its index-3 digit is accepted, it reloads from the FIFO head if the FIFO is non-empty; this gives zero-bubble output.
  - dig_last = 1 on index 3 of word N_WORDS-1.
- Error check:
  - A nibble > 9 or a non-zero [17:16] in a loaded word sets err.
  - The digit is still emitted unchanged.
- Reset:
  - Returns to IDLE; clears counters, the valid shift register and the FIFO.
  - Any data still in the ROM pipeline is discarded.
- Reset values: busy=0, done=0, err=0, mem_addr=0, dig_valid=0, dig_data=0, dig_last=0.

## Timing
- Latency (start sampled high at the end of cycle 0, dig_ready held high):
  - cycle 1: mem_addr = 0 is issued.
  - cycle 4: word 0 appears on mem_data and is written into the FIFO.
  - cycle 5: the unpacker loads word 0.
  - cycle 6: first dig_valid.
- Throughput: sustained 1 digit/cycle under full ready; the issue rate self-limits to 1 word per 4 cycles.
- Under backpressure: dig_data/dig_last stay stable while dig_valid is high and dig_ready is low. Issue stalls when credit runs out.
- busy is high from cycle 1 through the done cycle inclusive; done lands in the cycle after the last handshake.
- start coinciding with done: ignored.

## Structure
- Shared package pi_defs holds:
  - DIGITS_PER_WORD = 4 and DIGIT_W = 4
  - READ_LAT default
  - state encoding IDLE/RUN/DRAIN
- Sub-module: pi_word_fifo, a synchronous show-ahead FIFO.
  - Parameterised width/depth.
  - Exposes count; uses simultaneous push/pop when non-empty.

## Test plan
- Full-rate read, N_WORDS=3, ROM words 0x01415, 0x09265, 0x03589, ready=1 -> digits 1,4,1,5,9,2,6,5,3,5,8,9 on cycles 6..17; dig_last only at cycle 17; done at cycle 18.
- Backpressure: ready toggles 1/0 each cycle -> identical digit sequence, no drops or duplicates; fifo_count never exceeds 4.
- Long stall: ready=0 for 50 cycles after the first digit -> at most FIFO_DEPTH words outstanding; issue resumes after ready returns with no data loss.
- Bad word 0x2xxxx or nibble 0xA -> err rises the cycle after the word loads; digits still emitted; next accepted start clears err.
- rst_n low mid-DRAIN with reads in flight -> all outputs return to reset values next cycle; a new start produces a clean sequence from address 0 with no stale words.
- start asserted while busy and in the done cycle -> ignored; exactly one done pulse per accepted start.
